counter_bank: RTL

Parametrised bank of NCH independent SIZE-bit up/down counters, each with enable, direction and load, plus selectable wrap or saturate behaviour and sticky per-channel overflow flags. An optional registered full-width sum of all channel values replaces the fixed two-counter-plus-adder arrangement. The block sits beside the existing counter/adder logic as the general event-counting resource for the design.

---
 rtl/counter_bank.sv | 118 +++++++++++
 1 files changed

// File: rtl/counter_bank.sv
// counter_bank: NCH independent SIZE-bit up/down counters with load, wrap/saturate
// boundaries and sticky overflow flags. Define COUNTER_BANK_SUM_EN to build the
// registered full-width sum of all channel values; otherwise sum is tied to zero.
module counter_bank #(
   parameter  int SIZE = 10,
   parameter  int NCH  = 2,
   parameter  int SAT  = 0,
   localparam int CW   = $clog2(NCH),
   localparam int SUMW = SIZE + $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      en,
   input  logic [NCH-1:0]      dir,
   input  logic                ld,
   input  logic [CW-1:0]       ld_sel,
   input  logic [SIZE-1:0]     ld_val,
   input  logic [NCH-1:0]      clr_ovf,
   output logic [NCH*SIZE-1:0] val,
   output logic [NCH-1:0]      ovf,
   output logic [SUMW-1:0]     sum
);

   localparam logic [SIZE-1:0] MAX_VAL = {SIZE{1'b1}};
   localparam logic [SIZE-1:0] MIN_VAL = {SIZE{1'b0}};
   localparam logic [SIZE-1:0] ONE_VAL = {{(SIZE-1){1'b0}}, 1'b1};

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      // Out-of-range ld_sel values never match any channel index.
      localparam logic [CW-1:0] IDX = CW'(i);

      logic [SIZE-1:0] cnt_r;
      logic [SIZE-1:0] cnt_nxt_s;
      logic            ovf_r;
      logic            ovf_nxt_s;
      logic            hit_s;

      // next count (load > count > hold) and boundary-step detection
      always_comb begin
         cnt_nxt_s = cnt_r;
         hit_s     = 1'b0;
         if (ld && (ld_sel == IDX)) begin
            cnt_nxt_s = ld_val;
         end else if (en[i]) begin
            if (dir[i] == 1'b0) begin
               if (cnt_r == MAX_VAL) begin
                  hit_s     = 1'b1;
                  cnt_nxt_s = (SAT != 0) ? MAX_VAL : MIN_VAL;
               end else begin
                  cnt_nxt_s = cnt_r + ONE_VAL;
               end
            end else begin
               if (cnt_r == MIN_VAL) begin
                  hit_s     = 1'b1;
                  cnt_nxt_s = (SAT != 0) ? MIN_VAL : MAX_VAL;
               end else begin
                  cnt_nxt_s = cnt_r - ONE_VAL;
               end
            end
         end else begin
            cnt_nxt_s = cnt_r;
         end
      end

      // sticky flag: a boundary step outranks a clear in the same cycle
      always_comb begin
         ovf_nxt_s = ovf_r;
         if (hit_s) begin
            ovf_nxt_s = 1'b1;
         end else if (clr_ovf[i]) begin
            ovf_nxt_s = 1'b0;
         end else begin
            ovf_nxt_s = ovf_r;
         end
      end

      // channel state registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_r <= MIN_VAL;
            ovf_r <= 1'b0;
         end else begin
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_nxt_s;
         end
      end

      assign val[i*SIZE +: SIZE] = cnt_r;
      assign ovf[i]              = ovf_r;
   end

`ifdef COUNTER_BANK_SUM_EN
   logic [SUMW-1:0] sum_s;
   logic [SUMW-1:0] sum_r;

   // SUMW is wide enough that NCH maximal values never wrap
   always_comb begin
      sum_s = {SUMW{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         sum_s = sum_s + SUMW'(val[k*SIZE +: SIZE]);
      end
   end

   // sum register, one cycle behind val
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= {SUMW{1'b0}};
      end else begin
         sum_r <= sum_s;
      end
   end

   assign sum = sum_r;
`else
   assign sum = {SUMW{1'b0}};
`endif

endmodule
